// File: rtl/equiv_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// equiv_sweep_ctrl
//
// Self-timed sequencer for a two-circuit equivalence checker. On start it
// walks every input vector 0 .. 2^N_IN-1 (vec[N_IN-1] is A, vec[0] is E). It
// holds each vector for SETTLE_CYCLES clocks and samples the checker on the
// last clock of each hold. It collects the mismatch count, the first failing
// vector and a sticky flag for an inconsistent eq output.
//
// Configuration macro: STOP_ON_FAIL_EN
//   defined   -> the first eq==0 sample ends the sweep on that edge, with vec
//                frozen at the failing vector.
//   undefined -> the full sweep always runs and every mismatch is counted.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset (aborts a sweep)
//   start           in   begin a sweep; only honoured in IDLE or DONE
//   out1, out2      in   outputs of circuit 1 / circuit 2
//   eq              in   checker equality output (1 = match)
//   vec             out  applied input vector {A,B,C,D,E}
//   busy            out  sweep in progress
//   done            out  sweep complete (level until next start or rst)
//   pass            out  done && no mismatches && no eq fault
//   mismatch_cnt    out  number of samples with eq==0 (N_IN+1 bits, no wrap)
//   first_fail_vec  out  vector of the first eq==0 sample
//   first_fail_vld  out  first_fail_vec is valid
//   eq_fault        out  sticky: eq disagreed with (out1==out2) at a sample
//   dbg_state       out  current FSM state (0 IDLE, 1 SETTLE, 2 DONE)
//
// Handshake: start is a level sampled at each rising edge; it acts only when
// busy is low. There is no ready/valid back-pressure on the outputs. Results
// are valid while done is high.
// ---------------------------------------------------------------------------
module equiv_sweep_ctrl #(
  parameter int N_IN          = 5,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            out1,
  input  logic            out2,
  input  logic            eq,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld,
  output logic            eq_fault,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // A one-clock dwell still needs a 1-bit counter to keep the code uniform.
  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffv_vld_q, ffv_vld_d;
  logic              fault_q, fault_d;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    ffv_d     = ffv_q;
    ffv_vld_d = ffv_vld_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          vec_d     = '0;
          dwell_d   = '0;
          cnt_d     = '0;
          ffv_d     = '0;
          ffv_vld_d = 1'b0;
          fault_d   = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (dwell_q == DWELL_LAST) begin
          // Sample point: the vector has been stable for SETTLE_CYCLES clocks.
          if (!eq) begin
            cnt_d = cnt_q + (N_IN+1)'(1);
            if (!ffv_vld_q) begin
              ffv_d     = vec_q;
              ffv_vld_d = 1'b1;
            end
          end
          // The checker's eq must agree with its own two outputs.
          if (eq != (out1 == out2)) begin
            fault_d = 1'b1;
          end
`ifdef STOP_ON_FAIL_EN
          if (!eq || (vec_q == VEC_LAST)) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            dwell_d = '0;
          end
`else
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            dwell_d = '0;
          end
`endif
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      ffv_q     <= '0;
      ffv_vld_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      ffv_q     <= ffv_d;
      ffv_vld_q <= ffv_vld_d;
      fault_q   <= fault_d;
    end
  end

  assign vec            = vec_q;
  assign busy           = (state_q == ST_SETTLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (cnt_q == '0) && !fault_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffv_vld_q;
  assign eq_fault       = fault_q;
  assign dbg_state      = state_q;

endmodule
